// File: rtl/bus_interconnect_pkg.sv
// Shared state encoding, request record and per-system address map for the
// CPU-to-peripheral bus interconnect.
package bus_interconnect_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCESS  = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_RESPOND = 2'd3;

  typedef enum logic [1:0] {
    BUS_IDLE    = ST_IDLE,
    BUS_ACCESS  = ST_ACCESS,
    BUS_WAIT    = ST_WAIT,
    BUS_RESPOND = ST_RESPOND
  } bus_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [3:0]  write_mask;
    logic        write;
  } bus_req_t;

  localparam int MAX_DEVICES = 32;
  typedef logic [MAX_DEVICES-1:0] chip_select_t;

  // Default SoC address map; every device decodes to zero until the system overrides it.
  localparam int                            SYS_NUM_DEVICES    = 9;
  localparam logic [SYS_NUM_DEVICES*32-1:0] SYS_DEVICE_BASE    = '0;
  localparam logic [SYS_NUM_DEVICES*32-1:0] SYS_DEVICE_MASK    = '0;
  localparam int                            SYS_TIMEOUT_CYCLES = 15;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_decoder.sv
// Combinational priority decode of a byte address against per-device base/mask
// pairs; the lowest matching device index wins.
module bus_decoder
  import bus_interconnect_pkg::*;
#(
  parameter int                        NUM_DEVICES = SYS_NUM_DEVICES,
  parameter logic [NUM_DEVICES*32-1:0] DEVICE_BASE = SYS_DEVICE_BASE,
  parameter logic [NUM_DEVICES*32-1:0] DEVICE_MASK = SYS_DEVICE_MASK,
  parameter int                        IDX_W       = idx_width(NUM_DEVICES)
) (
  input  logic [31:0]      addr_i,
  output logic             hit_o,
  output logic [IDX_W-1:0] idx_o
);

  // Scan from the top down so the lowest matching index is the last one written.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = NUM_DEVICES - 1; i >= 0; i--) begin
      if ((addr_i & DEVICE_MASK[32*i +: 32]) == DEVICE_BASE[32*i +: 32]) begin
        hit_o = 1'b1;
        idx_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/bus_interconnect.sv
// CPU-to-peripheral interconnect: decode, one-cycle chip-select strobe, wait for the
// selected device's ready (bounded by a saturating timeout), then one registered response.
module bus_interconnect
  import bus_interconnect_pkg::*;
#(
  parameter int                        NUM_DEVICES    = SYS_NUM_DEVICES,
  parameter logic [NUM_DEVICES*32-1:0] DEVICE_BASE    = SYS_DEVICE_BASE,
  parameter logic [NUM_DEVICES*32-1:0] DEVICE_MASK    = SYS_DEVICE_MASK,
  parameter int                        TIMEOUT_CYCLES = SYS_TIMEOUT_CYCLES
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [31:0]                 req_addr_i,
  input  logic                        req_read_i,
  input  logic                        req_write_i,
  input  logic [31:0]                 req_write_data_i,
  input  logic [3:0]                  req_write_mask_i,
  output logic                        req_ready_o,
  output logic                        rsp_valid_o,
  output logic [31:0]                 rsp_data_o,
  output logic                        rsp_error_o,
  output logic [NUM_DEVICES-1:0]      dev_chip_select_o,
  output logic [31:0]                 dev_addr_o,
  output logic                        dev_read_enable_o,
  output logic [31:0]                 dev_write_data_o,
  output logic [3:0]                  dev_write_mask_o,
  input  logic [NUM_DEVICES*32-1:0]   dev_read_data_i,
  input  logic [NUM_DEVICES-1:0]      dev_ready_i
);

  localparam int               IDX_W     = idx_width(NUM_DEVICES);
  localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  bus_state_t             state_q, state_d;
  bus_req_t               req_q, req_d;
  logic [IDX_W-1:0]       sel_q, sel_d;
  logic [NUM_DEVICES-1:0] cs_q, cs_d;
  logic                   rd_en_q, rd_en_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   rsp_error_q, rsp_error_d;
  logic [31:0]            rsp_data_q, rsp_data_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic                   dec_hit;
  logic [IDX_W-1:0]       dec_idx;
  logic                   sel_ready;
  logic [31:0]            sel_rdata;

  bus_decoder #(
    .NUM_DEVICES (NUM_DEVICES),
    .DEVICE_BASE (DEVICE_BASE),
    .DEVICE_MASK (DEVICE_MASK),
    .IDX_W       (IDX_W)
  ) u_decoder (
    .addr_i (req_addr_i),
    .hit_o  (dec_hit),
    .idx_o  (dec_idx)
  );

  assign sel_ready = dev_ready_i[sel_q];
  assign sel_rdata = dev_read_data_i[{sel_q, 5'd0} +: 32];

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    sel_d       = sel_q;
    cs_d        = '0;
    rd_en_d     = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_error_d = 1'b0;
    rsp_data_d  = '0;
    cnt_d       = cnt_q;
    case (state_q)
      BUS_IDLE: begin
        if (req_read_i || req_write_i) begin
          // A simultaneous read+write is treated as a write.
          req_d.addr       = req_addr_i;
          req_d.write_data = req_write_data_i;
          req_d.write_mask = req_write_i ? req_write_mask_i : 4'h0;
          req_d.write      = req_write_i;
          sel_d            = dec_idx;
          if (dec_hit) begin
            state_d       = BUS_ACCESS;
            cs_d[dec_idx] = 1'b1;
            rd_en_d       = !req_write_i;
          end else begin
            state_d     = BUS_RESPOND;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
          end
        end
      end
      BUS_ACCESS: begin
        cnt_d   = '0;
        state_d = BUS_WAIT;
      end
      BUS_WAIT: begin
        if (sel_ready) begin
          state_d     = BUS_RESPOND;
          rsp_valid_d = 1'b1;
          rsp_data_d  = req_q.write ? 32'h0 : sel_rdata;
        end else begin
          if (cnt_q != CNT_LIMIT) cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_LIMIT) begin
            state_d     = BUS_RESPOND;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
          end
        end
      end
      BUS_RESPOND: state_d = BUS_IDLE;
      default:     state_d = BUS_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= BUS_IDLE;
      req_q       <= '0;
      sel_q       <= '0;
      cs_q        <= '0;
      rd_en_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_data_q  <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      sel_q       <= sel_d;
      cs_q        <= cs_d;
      rd_en_q     <= rd_en_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_data_q  <= rsp_data_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready_o       = (state_q == BUS_IDLE);
  assign rsp_valid_o       = rsp_valid_q;
  assign rsp_data_o        = rsp_data_q;
  assign rsp_error_o       = rsp_error_q;
  assign dev_chip_select_o = cs_q;
  assign dev_addr_o        = req_q.addr;
  assign dev_read_enable_o = rd_en_q;
  assign dev_write_data_o  = req_q.write_data;
  assign dev_write_mask_o  = req_q.write_mask;

endmodule

// File: tb/tb_bus_interconnect.sv
// Randomised scoreboard bench for bus_interconnect: the stimulus side predicts each
// chip-select strobe and response (cycle, data, error) and a monitor checks them.
module tb_bus_interconnect;

  localparam int NDEV = 3;
  localparam int TMO  = 8;
  localparam logic [NDEV*32-1:0] BASE = {32'h0000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [NDEV*32-1:0] MASK = {32'hFF00_0000, 32'hF000_0000, 32'hF000_0000};

  // Address map as seen by the reference model.
  logic [31:0] m_base [NDEV] = '{32'h0000_0000, 32'h1000_0000, 32'h0000_0000};
  logic [31:0] m_mask [NDEV] = '{32'hF000_0000, 32'hF000_0000, 32'hFF00_0000};

  logic                 clk = 1'b0;
  logic                 reset_i = 1'b1;
  logic [31:0]          req_addr_i = '0;
  logic                 req_read_i = 1'b0;
  logic                 req_write_i = 1'b0;
  logic [31:0]          req_write_data_i = '0;
  logic [3:0]           req_write_mask_i = '0;
  logic                 req_ready_o;
  logic                 rsp_valid_o;
  logic [31:0]          rsp_data_o;
  logic                 rsp_error_o;
  logic [NDEV-1:0]      dev_chip_select_o;
  logic [31:0]          dev_addr_o;
  logic                 dev_read_enable_o;
  logic [31:0]          dev_write_data_o;
  logic [3:0]           dev_write_mask_o;
  logic [NDEV*32-1:0]   dev_read_data_i = '0;
  logic [NDEV-1:0]      dev_ready_i = '0;

  bus_interconnect #(
    .NUM_DEVICES    (NDEV),
    .DEVICE_BASE    (BASE),
    .DEVICE_MASK    (MASK),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i             (clk),
    .reset_i           (reset_i),
    .req_addr_i        (req_addr_i),
    .req_read_i        (req_read_i),
    .req_write_i       (req_write_i),
    .req_write_data_i  (req_write_data_i),
    .req_write_mask_i  (req_write_mask_i),
    .req_ready_o       (req_ready_o),
    .rsp_valid_o       (rsp_valid_o),
    .rsp_data_o        (rsp_data_o),
    .rsp_error_o       (rsp_error_o),
    .dev_chip_select_o (dev_chip_select_o),
    .dev_addr_o        (dev_addr_o),
    .dev_read_enable_o (dev_read_enable_o),
    .dev_write_data_o  (dev_write_data_o),
    .dev_write_mask_o  (dev_write_mask_o),
    .dev_read_data_i   (dev_read_data_i),
    .dev_ready_i       (dev_ready_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] data;
  } rsp_exp_t;

  typedef struct {
    int              cyc;
    logic [NDEV-1:0] cs;
    logic [31:0]     addr;
    logic            rd_en;
    logic [31:0]     wdata;
    logic [3:0]      mask;
  } cs_exp_t;

  rsp_exp_t rsp_q [$];
  cs_exp_t  cs_q  [$];
  rsp_exp_t mon_r;
  cs_exp_t  mon_c;
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic int model_decode(input logic [31:0] addr);
    for (int i = 0; i < NDEV; i++)
      if ((addr & m_mask[i]) == m_base[i]) return i;
    return -1;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready_o, 1);
    check({tag, "_rsp_valid"}, rsp_valid_o, 0);
    check({tag, "_rsp_data"},  rsp_data_o, 0);
    check({tag, "_rsp_error"}, rsp_error_o, 0);
    check({tag, "_cs"},        dev_chip_select_o, 0);
    check({tag, "_dev_addr"},  dev_addr_o, 0);
    check({tag, "_rd_en"},     dev_read_enable_o, 0);
    check({tag, "_wdata"},     dev_write_data_o, 0);
    check({tag, "_wmask"},     dev_write_mask_o, 0);
  endtask

  // Monitor: compare every strobe/response the DUT presents against the queued predictions.
  always @(negedge clk) begin
    if (rsp_valid_o) begin
      if (rsp_q.size() == 0) check("rsp_unexpected", rsp_valid_o, 0);
      else begin
        mon_r = rsp_q.pop_front();
        check("rsp_cycle", cyc, mon_r.cyc);
        check("rsp_error", rsp_error_o, mon_r.err);
        check("rsp_data",  rsp_data_o, mon_r.data);
      end
    end else if (rsp_q.size() != 0 && rsp_q[0].cyc <= cyc) begin
      check("rsp_missing", rsp_valid_o, 1);
      void'(rsp_q.pop_front());
    end
    if (dev_chip_select_o != '0) begin
      if (cs_q.size() == 0) check("cs_unexpected", dev_chip_select_o, 0);
      else begin
        mon_c = cs_q.pop_front();
        check("cs_cycle",  cyc, mon_c.cyc);
        check("cs_onehot", dev_chip_select_o, mon_c.cs);
        check("dev_addr",  dev_addr_o, mon_c.addr);
        check("dev_rd_en", dev_read_enable_o, mon_c.rd_en);
        check("dev_wdata", dev_write_data_o, mon_c.wdata);
        check("dev_wmask", dev_write_mask_o, mon_c.mask);
      end
    end else begin
      if (dev_read_enable_o) check("rd_en_without_cs", dev_read_enable_o, 0);
      if (cs_q.size() != 0 && cs_q[0].cyc <= cyc) begin
        check("cs_missing", dev_chip_select_o, cs_q[0].cs);
        void'(cs_q.pop_front());
      end
    end
  end

  // One transaction. dly = cycles after the strobe at which the target pulses ready;
  // rst_at != 0 pulses reset_i that many cycles after acceptance instead of completing.
  // Called and returns 1 time unit after a rising edge with the DUT idle.
  task automatic run_txn(input logic [31:0] addr, input logic rd, input logic wr,
                         input logic [31:0] wd, input logic [3:0] wm,
                         input int dly, input int rst_at);
    int dev, n, r, end_c;
    logic tmo, busy;
    logic [NDEV-1:0] noise;
    logic [NDEV*32-1:0] rdat;
    rsp_exp_t er;
    cs_exp_t ec;
    dev = model_decode(addr);
    for (int i = 0; i < NDEV; i++) rdat[32*i +: 32] = $urandom;
    dev_read_data_i  = rdat;
    req_addr_i       = addr;
    req_read_i       = rd;
    req_write_i      = wr;
    req_write_data_i = wd;
    req_write_mask_i = wm;
    @(negedge clk);
    n = cyc;
    check("req_ready_idle", req_ready_o, 1);
    tmo = (dev >= 0) && (dly > TMO);
    if (dev < 0)  r = n + 1;
    else if (tmo) r = n + 2 + TMO;
    else          r = n + 2 + dly;
    if (rst_at == 0) begin
      er.cyc  = r;
      er.err  = (dev < 0) || tmo;
      er.data = (dev >= 0 && !tmo && !wr) ? rdat[32*dev +: 32] : 32'h0;
      rsp_q.push_back(er);
    end
    if (dev >= 0) begin
      ec.cyc      = n + 1;
      ec.cs       = '0;
      ec.cs[dev]  = 1'b1;
      ec.addr     = addr;
      ec.rd_en    = !wr;
      ec.wdata    = wd;
      ec.mask     = wr ? wm : 4'h0;
      cs_q.push_back(ec);
    end
    if (rst_at != 0)                      end_c = n + rst_at + 1;
    else if (dev >= 0 && n + 1 + dly > r) end_c = n + 2 + dly;
    else                                  end_c = r + 1;
    for (int c = n + 1; c <= end_c; c++) begin
      @(posedge clk);
      #1;
      // Junk requests while busy must be ignored.
      busy             = (rst_at != 0) ? (c < n + rst_at) : (c <= r);
      req_read_i       = busy;
      req_write_i      = busy & $urandom_range(0, 1);
      req_addr_i       = $urandom;
      req_write_data_i = $urandom;
      req_write_mask_i = 4'($urandom);
      noise            = NDEV'($urandom);
      if (dev >= 0) noise[dev] = (c == n + 1 + dly);
      dev_ready_i      = noise;
      reset_i          = (rst_at != 0) && (c == n + rst_at);
    end
    if (rst_at != 0) begin
      @(negedge clk);
      check_idle_outputs("after_reset");
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  op;
    int          sel;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk);
    #1;
    reset_i = 1'b0;

    run_txn(32'h1000_0004, 1, 0, 32'h1111_2222, 4'hF, 1, 0);      // dev1 read, 3-cycle latency
    run_txn(32'hF000_0000, 1, 0, 32'h0, 4'h0, 1, 0);              // decode miss
    run_txn(32'h0000_0100, 0, 1, 32'hCAFE_F00D, 4'h3, TMO + 2, 0); // timeout, late ready ignored
    run_txn(32'h0000_0040, 1, 0, 32'h0, 4'h0, 2, 0);              // overlap: lowest index wins
    run_txn(32'h1000_0010, 1, 1, 32'h5A5A_A5A5, 4'hA, 1, 0);      // read+write acts as write
    run_txn(32'h1000_0020, 1, 0, 32'h0, 4'h0, 7, 0);              // slow device, response at N+9
    run_txn(32'h0800_0000, 1, 0, 32'h0, 4'h0, TMO, 0);            // ready in last WAIT cycle
    run_txn(32'h0100_0000, 0, 1, 32'h1234_5678, 4'hC, TMO + 1, 0); // first cycle past the limit
    run_txn(32'h1000_0008, 1, 0, 32'h0, 4'h0, 6, 3);              // reset during WAIT
    run_txn(32'h1000_000C, 1, 0, 32'h0, 4'h0, 1, 0);              // recovers normally

    for (int k = 0; k < 40; k++) begin
      a   = $urandom;
      sel = $urandom_range(0, 3);
      case (sel)
        0:       a[31:28] = 4'h0;
        1:       a[31:28] = 4'h1;
        2:       a[31:24] = 8'h00;
        default: a[31:28] = 4'h8;
      endcase
      op = 2'($urandom_range(1, 3));
      run_txn(a, op[0], op[1], $urandom, 4'($urandom), $urandom_range(1, TMO + 3), 0);
    end

    req_read_i  = 1'b0;
    req_write_i = 1'b0;
    dev_ready_i = '0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("rsp_queue_drained", rsp_q.size(), 0);
    check("cs_queue_drained", cs_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
